// File: rtl/redmule_mem_port_arbiter.sv
// rtl/redmule_mem_port_arbiter.sv - burst arbiter sharing the RedMulE memory port among stream channels
module redmule_mem_port_arbiter #(
    parameter int unsigned NR       = 6,
    parameter int unsigned ZIDX     = 3,
    parameter int unsigned BURST    = 8,
    parameter int unsigned MAX_WAIT = 64,
    localparam int unsigned SEL_W   = $clog2(NR)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              z_priority_i,
    input  logic [NR-1:0]     req_i,
    output logic [NR-1:0]     gnt_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              busy_o,
    output logic [NR-1:0]     starve_o
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
    logic               owner_rr_q, owner_rr_d;
    logic [CW-1:0]      wait_q [NR];
    logic [CW-1:0]      wait_d [NR];
    logic [NR-1:0]      starve;

    logic               win_found;
    logic               win_rr;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   rr_idx;
    logic               st_found;
    logic [SEL_W-1:0]   st_idx;
    logic [SEL_W:0]     cand;
    logic [SEL_W-1:0]   owner_next;

    // Pointer value after an exit from a round-robin win
    assign owner_next = (owner_q == SEL_W'(NR - 1)) ? '0 : owner_q + 1'b1;

    assign sel_o    = owner_q;
    assign busy_o   = (state_q == LOCKED);
    assign starve_o = starve;

    // Starvation flag straight from the registered wait counters
    always_comb begin
        starve = '0;
        for (int i = 0; i < NR; i++) begin
            starve[i] = (wait_q[i] == CW'(MAX_WAIT));
        end
    end

    // Winner selection: starving (lowest index) > Z priority > round-robin from rr_ptr
    always_comb begin
        win_found = 1'b0;
        rr_idx    = '0;
        cand      = '0;
        for (int k = 0; k < NR; k++) begin
            cand = {1'b0, rr_ptr_q} + (SEL_W + 1)'(k);
            if (cand >= (SEL_W + 1)'(NR)) begin
                cand = cand - (SEL_W + 1)'(NR);
            end
            if (!win_found && req_i[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                rr_idx    = cand[SEL_W-1:0];
            end
        end

        st_found = 1'b0;
        st_idx   = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (req_i[k] && starve[k]) begin
                st_found = 1'b1;
                st_idx   = SEL_W'(k);
            end
        end

        if (st_found) begin
            win_idx = st_idx;
            win_rr  = 1'b0;
        end else if (z_priority_i && req_i[ZIDX]) begin
            win_idx = SEL_W'(ZIDX);
            win_rr  = 1'b0;
        end else begin
            win_idx = rr_idx;
            win_rr  = 1'b1;
        end
    end

    // Arbitration FSM next-state and port outputs
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        owner_rr_d = owner_rr_q;
        mem_req_o  = 1'b0;
        gnt_o      = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = LOCKED;
                    owner_d    = win_idx;
                    owner_rr_d = win_rr;
                    beat_cnt_d = '0;
                end
            end
            LOCKED: begin
                mem_req_o = req_i[owner_q];
                if (!req_i[owner_q]) begin
                    // Early release: owner withdrew, no beat this cycle
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    if (owner_rr_q) rr_ptr_d = owner_next;
                end else if (mem_gnt_i) begin
                    gnt_o[owner_q] = 1'b1;
                    if (beat_cnt_q == BW'(BURST - 1)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        if (owner_rr_q) rr_ptr_d = owner_next;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Wait counters: count while requesting and not being served, saturate at MAX_WAIT
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            wait_d[i] = wait_q[i];
            if (!req_i[i]) begin
                wait_d[i] = '0;
            end else if ((state_q == IDLE) && (win_idx == SEL_W'(i))) begin
                wait_d[i] = '0;
            end else if ((state_q == LOCKED) && (owner_q == SEL_W'(i))) begin
                wait_d[i] = wait_q[i];
            end else if (wait_q[i] != CW'(MAX_WAIT)) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    // FSM and arbitration state registers; soft clear beats every other update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            owner_rr_q <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            owner_rr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            owner_rr_q <= owner_rr_d;
        end
    end

    // Wait counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR; i++) wait_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NR; i++) wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < NR; i++) wait_q[i] <= wait_d[i];
        end
    end

endmodule

// File: tb/tb_redmule_mem_port_arbiter.sv
// tb/tb_redmule_mem_port_arbiter.sv - self-checking bench for redmule_mem_port_arbiter
module tb_redmule_mem_port_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clear_i;
    logic       z_priority_i;
    logic [5:0] req_i;
    logic [5:0] gnt_o;
    logic       mem_req_o;
    logic       mem_gnt_i;
    logic [2:0] sel_o;
    logic       busy_o;
    logic [5:0] starve_o;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int mon_idx;

    typedef struct {
        logic [5:0] req;
        logic       zp;
        logic       exp_busy;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t tbl[9];

    always #5 clk_i = ~clk_i;

    redmule_mem_port_arbiter #(
        .NR(6), .ZIDX(3), .BURST(8), .MAX_WAIT(64)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .z_priority_i (z_priority_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .sel_o        (sel_o),
        .busy_o       (busy_o),
        .starve_o     (starve_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk_i);
    endtask

    task automatic do_clear();
        clear_i   = 1'b1;
        req_i     = '0;
        mem_gnt_i = 1'b0;
        next_cycle();
        clear_i   = 1'b0;
    endtask

    // Scoreboard: every granted beat must match the next expected owner
    always @(negedge clk_i) begin
        if (gnt_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt_o), 0);
            end else begin
                mon_idx = exp_q.pop_front();
                chk("gnt_onehot", 32'(gnt_o), 32'(1 << mon_idx));
                chk("gnt_sel", 32'(sel_o), 32'(mon_idx));
            end
        end
    end

    initial begin
        tbl[0] = '{6'b000001, 1'b0, 1'b1, 3'd0};
        tbl[1] = '{6'b000010, 1'b0, 1'b1, 3'd1};
        tbl[2] = '{6'b100000, 1'b0, 1'b1, 3'd5};
        tbl[3] = '{6'b001001, 1'b0, 1'b1, 3'd0};
        tbl[4] = '{6'b001001, 1'b1, 1'b1, 3'd3};
        tbl[5] = '{6'b001000, 1'b0, 1'b1, 3'd3};
        tbl[6] = '{6'b110000, 1'b1, 1'b1, 3'd4};
        tbl[7] = '{6'b101100, 1'b0, 1'b1, 3'd2};
        tbl[8] = '{6'b000000, 1'b1, 1'b0, 3'd0};

        rst_ni = 1'b0; clear_i = 1'b0; z_priority_i = 1'b0; req_i = '0; mem_gnt_i = 1'b0;
        repeat (2) @(posedge clk_i);
        to_neg();
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_sel", 32'(sel_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_starve", 32'(starve_o), 0);
        rst_ni = 1'b1;
        next_cycle();

        // Arbitration table from a cleared state (rr_ptr 0), memory never grants
        for (int v = 0; v < 9; v++) begin
            do_clear();
            req_i = tbl[v].req;
            z_priority_i = tbl[v].zp;
            to_neg();
            chk("tbl_idle_mem_req", 32'(mem_req_o), 0);
            next_cycle();
            to_neg();
            chk("tbl_busy", 32'(busy_o), 32'(tbl[v].exp_busy));
            chk("tbl_mem_req", 32'(mem_req_o), 32'(tbl[v].exp_busy));
            chk("tbl_sel", 32'(sel_o), 32'(tbl[v].exp_sel));
            next_cycle();
        end
        z_priority_i = 1'b0;

        // Single requester: two full bursts with a bubble in between
        do_clear();
        repeat (16) exp_q.push_back(0);
        req_i = 6'b000001; mem_gnt_i = 1'b1;
        for (int k = 0; k < 18; k++) begin
            to_neg();
            chk("single_mem_req", 32'(mem_req_o), (k % 9 == 0) ? 0 : 1);
            next_cycle();
        end
        req_i = '0;
        to_neg();
        chk("single_drained", exp_q.size(), 0);
        next_cycle();

        // Round-robin between X and W
        do_clear();
        repeat (8) exp_q.push_back(0);
        repeat (8) exp_q.push_back(1);
        repeat (8) exp_q.push_back(0);
        req_i = 6'b000011; mem_gnt_i = 1'b1;
        for (int k = 0; k < 27; k++) begin
            to_neg();
            if (k == 9)  chk("rr_ptr_after_x", 32'(dut.rr_ptr_q), 1);
            if (k == 18) chk("rr_ptr_after_w", 32'(dut.rr_ptr_q), 2);
            next_cycle();
        end
        req_i = '0;
        to_neg();
        chk("rr_ptr_after_x2", 32'(dut.rr_ptr_q), 1);
        chk("rr_drained", exp_q.size(), 0);
        next_cycle();

        // Z priority starving X until the wait counter saturates
        do_clear();
        repeat (64) exp_q.push_back(3);
        repeat (8) exp_q.push_back(0);
        z_priority_i = 1'b1; req_i = 6'b001001; mem_gnt_i = 1'b1;
        for (int k = 0; k < 81; k++) begin
            to_neg();
            if (k == 63) chk("zp_no_starve_yet", 32'(starve_o), 0);
            if (k == 64) chk("zp_starve_x", 32'(starve_o), 32'h01);
            if (k == 72) chk("zp_bubble", 32'(mem_req_o), 0);
            if (k == 73) chk("zp_starve_cleared", 32'(starve_o), 0);
            next_cycle();
        end
        req_i = '0;
        to_neg();
        chk("zp_rr_unchanged", 32'(dut.rr_ptr_q), 0);
        chk("zp_drained", exp_q.size(), 0);
        next_cycle();
        z_priority_i = 1'b0;

        // Early release of W after three beats
        do_clear();
        repeat (3) exp_q.push_back(1);
        req_i = 6'b000010; mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_neg();
            next_cycle();
        end
        req_i = '0;
        to_neg();
        chk("early_mem_req", 32'(mem_req_o), 0);
        chk("early_still_locked", 32'(busy_o), 1);
        next_cycle();
        to_neg();
        chk("early_idle", 32'(busy_o), 0);
        chk("early_rr_ptr", 32'(dut.rr_ptr_q), 2);
        chk("early_drained", exp_q.size(), 0);
        next_cycle();

        // Backpressure on Y; rr_ptr 2 picks Y over X
        repeat (8) exp_q.push_back(2);
        req_i = 6'b000101;
        for (int k = 0; k < 17; k++) begin
            mem_gnt_i = (k % 2 == 0);
            to_neg();
            if (k % 2 == 1) chk("bp_mem_req_held", 32'(mem_req_o), 1);
            next_cycle();
        end
        req_i = '0; mem_gnt_i = 1'b1;
        to_neg();
        chk("bp_idle", 32'(busy_o), 0);
        chk("bp_rr_ptr", 32'(dut.rr_ptr_q), 3);
        chk("bp_drained", exp_q.size(), 0);
        next_cycle();

        // Soft clear during X's fourth beat (rr_ptr 3 beforehand)
        repeat (4) exp_q.push_back(0);
        req_i = 6'b000001; mem_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clear_i = (k == 4);
            to_neg();
            next_cycle();
        end
        clear_i = 1'b0; req_i = '0;
        to_neg();
        chk("clr_busy", 32'(busy_o), 0);
        chk("clr_mem_req", 32'(mem_req_o), 0);
        chk("clr_sel", 32'(sel_o), 0);
        chk("clr_rr_ptr", 32'(dut.rr_ptr_q), 0);
        chk("clr_starve", 32'(starve_o), 0);
        chk("clr_drained", exp_q.size(), 0);
        next_cycle();

        // Asynchronous reset in the middle of W's second burst
        repeat (10) exp_q.push_back(1);
        req_i = 6'b000010; mem_gnt_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            to_neg();
            next_cycle();
        end
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_mem_req", 32'(mem_req_o), 0);
        chk("arst_gnt", 32'(gnt_o), 0);
        chk("arst_sel", 32'(sel_o), 0);
        chk("arst_rr_ptr", 32'(dut.rr_ptr_q), 0);
        to_neg();
        rst_ni = 1'b1;
        req_i = '0;
        next_cycle();
        to_neg();
        chk("arst_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/redmule_mem_port_arbiter.md
Name: redmule_mem_port_arbiter

Overview:
- Shares the single memory port among the RedMulE stream channels: X, W, Y, Z, X_exp and W_exp.
- Grants the port to one requester at a time, in bursts of up to BURST beats.
- Z sink can be prioritised via z_priority_i; otherwise round-robin among the others.
- Per-requester wait counters force service of any stream stuck for MAX_WAIT cycles.
- Sits between the streamer channel request lines and the memory interface, downstream of the memory scheduler.

Parameters:
- NR, 6, number of requesters (index 0 X, 1 W, 2 Y, 3 Z, 4 X_exp, 5 W_exp)
- ZIDX, 3, index of the Z sink requester
- BURST, 8, max beats per grant before re-arbitration (>=1)
- MAX_WAIT, 64, wait cycles after which a requester is starving (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- z_priority_i  in  1  Z requester wins arbitration when requesting
- req_i  in  NR  per-requester beat request (level, held until granted)
- gnt_o  out  NR  per-requester beat accepted (one-hot or zero)
- mem_req_o  out  1  request to memory port
- mem_gnt_i  in  1  memory accepted current beat
- sel_o  out  $clog2(NR)  index of current owner (drives the data mux)
- busy_o  out  1  FSM in LOCKED
- starve_o  out  NR  wait counter saturated at MAX_WAIT

Behaviour:
- Reset and clear_i values: FSM IDLE, owner 0, rr_ptr 0, beat_cnt 0, all wait counters 0.
- Output reset values: mem_req_o 0, gnt_o 0, sel_o 0, busy_o 0, starve_o 0.
- clear_i has priority over every other update in the same cycle.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - mem_req_o=0, gnt_o=0.
  - If any req_i bit is set, pick a winner. Priority order:
    1. Lowest-index requesting bit with starve_o set.
    2. ZIDX, if z_priority_i and req_i[ZIDX].
    3. First requesting index at or after rr_ptr, cyclically.
  - Register the winner as owner, go to LOCKED, beat_cnt=0.
  - Arbitration latency is 1 cycle: req_i in cycle t gives mem_req_o in t+1.
- LOCKED:
  - sel_o=owner.
  - mem_req_o=req_i[owner].
  - gnt_o[owner]=mem_gnt_i & req_i[owner]; all other gnt_o bits are 0.
  - beat_cnt increments on each granted beat.
  - Exit to IDLE when a granted beat occurs with beat_cnt==BURST-1, or when req_i[owner]==0 (early release, no beat that cycle).
  - One IDLE bubble cycle always follows an exit.
- rr_ptr:
  - Updated to (owner+1) mod NR on exit, only if the owner was a round-robin (case 3) win.
  - Starvation and Z-priority wins leave rr_ptr unchanged.
- Wait counters, width $clog2(MAX_WAIT+1), one per requester i:
  - Increment each cycle req_i[i]=1 and i is not the LOCKED owner.
  - Saturate at MAX_WAIT.
  - Clear to 0 when i becomes owner or req_i[i]=0.
  - starve_o[i] = (counter == MAX_WAIT), registered.
- mem_gnt_i while mem_req_o=0 is ignored.
- A simultaneous final beat and req_i drop takes the granted-beat path: the beat counts, then exit.
- sel_o holds its last owner value while in IDLE.

Test Plan:
- Single requester: req_i=6'b000001 held, mem_gnt_i=1.
  -> mem_req_o rises 1 cycle later; gnt_o[0] high 8 cycles; IDLE bubble; re-grant; sel_o=0.
- Round-robin: req_i=6'b000011, mem_gnt_i=1, z_priority_i=0.
  -> bursts alternate X(8), W(8), X(8); rr_ptr 1, 2, 1.
- Z priority: req_i=6'b001001, z_priority_i=1.
  -> Z wins every arbitration; X starve_o[0] asserts after 64 waiting cycles; next arbitration grants X; rr_ptr unchanged.
- Early release: owner W, req_i[1] drops after 3 granted beats.
  -> exit to IDLE with 3 gnt_o pulses; rr_ptr=2.
- Backpressure: owner Y, mem_gnt_i toggles 1,0,1,0.
  -> gnt_o[2] only on mem_gnt_i=1; burst ends after 8 granted beats (16 cycles).
- Clear mid-burst: clear_i at beat 4 of X.
  -> next cycle IDLE, outputs 0, rr_ptr 0, counters 0; async rst_ni mid-burst gives the same result immediately.
